// File: rtl/usb_in_sched_pkg.sv
// Package for the USB IN endpoint transmit scheduler.
// Holds the scheduler state encoding, the packet-length and endpoint-number
// widths, and the length clamp helper. All scheduler files import it.
package usb_in_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    NAKWAIT = 2'd2
  } state_t;

  localparam int LEN_W = 12;  // txdat_len / per-source byte count width
  localparam int EP_W  = 4;   // USB endpoint number width

  // Packet length offered to the controller: what the source holds,
  // clamped to the maximum packet size.
  function automatic logic [LEN_W-1:0] min_len(input logic [LEN_W-1:0] avail,
                                               input logic [LEN_W-1:0] max_len);
    return (avail > max_len) ? max_len : avail;
  endfunction

endpackage

// File: rtl/usb_in_ep_mux.sv
// NUM_EP-way source selector for the IN transmit scheduler.
// Picks the byte count and head byte of source sel_i and produces a one-hot
// decode of sel_i. An index outside 0..NUM_EP-1 selects nothing (all zero).
// Ports:
//   sel_i       source index
//   ep_avail_i  packed per-source byte counts, source 0 in the LSBs
//   ep_dat_i    packed per-source head bytes, source 0 in the LSBs
//   avail_o     byte count of the selected source
//   dat_o       head byte of the selected source
//   sel_oh_o    one-hot decode of sel_i
module usb_in_ep_mux
  import usb_in_sched_pkg::*;
#(
  parameter int NUM_EP = 4
) (
  input  logic [EP_W-1:0]         sel_i,
  input  logic [NUM_EP*LEN_W-1:0] ep_avail_i,
  input  logic [NUM_EP*8-1:0]     ep_dat_i,
  output logic [LEN_W-1:0]        avail_o,
  output logic [7:0]              dat_o,
  output logic [NUM_EP-1:0]       sel_oh_o
);

  always_comb begin
    avail_o  = '0;
    dat_o    = '0;
    sel_oh_o = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (sel_i == EP_W'(i)) begin
        avail_o     = ep_avail_i[i*LEN_W +: LEN_W];
        dat_o       = ep_dat_i[i*8 +: 8];
        sel_oh_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_in_ep_tx_sched.sv
// USB IN endpoint transmit scheduler.
// Shares the controller's single IN transmit port (txdat/txcork/txpop) between
// NUM_EP first-word-fall-through byte FIFOs. Endpoint numbers 1..NUM_EP map to
// source index 0..NUM_EP-1. While idle it tracks the controller's current
// endpoint and presents txcork/txdat_len for it; during a transaction it
// freezes the selection and steers txpop to the chosen FIFO.
// Optional feature: define USB_IN_ZLP_EN to send a zero-length packet after a
// full MAX_PKT packet that emptied its source.
// Ports:
//   clk_i, reset_i     PHY_CLKOUT clock, asynchronous active-high reset
//   usbrst_i           USB bus reset, synchronous abort to IDLE
//   endpt_i            current endpoint number from the controller
//   txact_i            IN transaction in progress
//   txpop_i            controller takes one byte this cycle
//   txpktfin_i         controller finished the packet
//   txcork_o           1 = nothing to send for this endpoint (NAK)
//   txdat_len_o        packet length in bytes
//   txdat_o            byte for the controller (valid in SEND)
//   ep_avail_i         packed per-source byte counts
//   ep_dat_i           packed per-source head bytes
//   ep_rd_o            one-hot pop strobe to the sources
//   ep_busy_o          source currently being drained
//   overpop_o          sticky: a pop arrived beyond the committed length
module usb_in_ep_tx_sched
  import usb_in_sched_pkg::*;
#(
  parameter int NUM_EP  = 4,
  parameter int MAX_PKT = 512
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    usbrst_i,
  input  logic [EP_W-1:0]         endpt_i,
  input  logic                    txact_i,
  input  logic                    txpop_i,
  input  logic                    txpktfin_i,
  output logic                    txcork_o,
  output logic [LEN_W-1:0]        txdat_len_o,
  output logic [7:0]              txdat_o,
  input  logic [NUM_EP*LEN_W-1:0] ep_avail_i,
  input  logic [NUM_EP*8-1:0]     ep_dat_i,
  output logic [NUM_EP-1:0]       ep_rd_o,
  output logic [NUM_EP-1:0]       ep_busy_o,
  output logic                    overpop_o
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT);
  localparam logic [EP_W:0]    EP_LAST = (EP_W+1)'(NUM_EP);

  state_t           state_q;
  logic [EP_W-1:0]  sel_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             cork_q;
  logic             overpop_q;
  logic             txact_q;

  logic [EP_W-1:0]   sel_d;
  logic [EP_W-1:0]   mux_sel;
  logic [LEN_W-1:0]  avail;
  logic [7:0]        dat;
  logic [NUM_EP-1:0] sel_oh;
  logic              hit;
  logic [LEN_W-1:0]  len_d;
  logic              cork_d;
  logic              act_rise;
  logic              act_fall;
  logic              pop_ok;
  logic              pop_over;

  // Endpoint 0 wraps to an out-of-range index, which the mux treats as empty.
  assign sel_d = endpt_i - EP_W'(1);
  assign hit   = (endpt_i != '0) && ({1'b0, endpt_i} <= EP_LAST);

  // While idle the mux follows the live endpoint so outputs lag it by one
  // cycle; otherwise it stays on the frozen selection.
  assign mux_sel = (state_q == IDLE) ? sel_d : sel_q;

  usb_in_ep_mux #(
    .NUM_EP(NUM_EP)
  ) u_mux (
    .sel_i     (mux_sel),
    .ep_avail_i(ep_avail_i),
    .ep_dat_i  (ep_dat_i),
    .avail_o   (avail),
    .dat_o     (dat),
    .sel_oh_o  (sel_oh)
  );

  assign len_d = hit ? min_len(avail, MAX_LEN) : '0;

  assign act_rise = txact_i && !txact_q;
  assign act_fall = !txact_i && txact_q;

  // Bus reset kills the strobe in the same cycle, before the state changes.
  assign pop_ok   = (state_q == SEND) && txpop_i && (cnt_q < len_q) && !usbrst_i;
  assign pop_over = (state_q == SEND) && txpop_i && (cnt_q >= len_q) && !usbrst_i;

`ifdef USB_IN_ZLP_EN
  logic [NUM_EP-1:0] zlp_q;
  logic              zlp_pend;
  logic              zlp_set;

  always_comb begin
    zlp_pend = 1'b0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (sel_d == EP_W'(i)) zlp_pend = zlp_q[i];
    end
  end

  // A simultaneous final pop counts toward the full packet and the emptied source.
  assign zlp_set = ((cnt_q + LEN_W'(pop_ok)) == MAX_LEN) &&
                   ((avail - LEN_W'(pop_ok)) == '0);

  assign cork_d = !hit || ((len_d == '0) && !(zlp_pend && (avail == '0)));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      zlp_q <= '0;
    end else if (usbrst_i) begin
      zlp_q <= '0;
    end else if ((state_q == SEND) && txpktfin_i) begin
      for (int i = 0; i < NUM_EP; i++) begin
        if (sel_q == EP_W'(i)) begin
          if (zlp_set)           zlp_q[i] <= 1'b1;
          else if (len_q == '0)  zlp_q[i] <= 1'b0;
        end
      end
    end
  end
`else
  assign cork_d = !hit || (len_d == '0);
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      cork_q    <= 1'b1;
      overpop_q <= 1'b0;
      txact_q   <= 1'b0;
    end else begin
      txact_q <= txact_i;
      if (pop_over) overpop_q <= 1'b1;

      if (usbrst_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        cork_q  <= 1'b1;
        len_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (act_rise) begin
              // Selection and length freeze for the whole transaction.
              state_q <= cork_q ? NAKWAIT : SEND;
              cnt_q   <= '0;
            end else begin
              sel_q  <= sel_d;
              cork_q <= cork_d;
              len_q  <= len_d;
            end
          end
          SEND: begin
            if (pop_ok) cnt_q <= cnt_q + LEN_W'(1);
            // A pop in the finishing cycle is still forwarded above.
            if (txpktfin_i || act_fall) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
          NAKWAIT: begin
            if (act_fall) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign txcork_o    = cork_q;
  assign txdat_len_o = len_q;
  assign txdat_o     = dat;
  assign overpop_o   = overpop_q;
  assign ep_rd_o     = {NUM_EP{pop_ok}} & sel_oh;
  assign ep_busy_o   = (state_q == SEND) ? sel_oh : '0;

endmodule

// File: tb/tb_usb_in_ep_tx_sched.sv
// Scoreboard bench for usb_in_ep_tx_sched. The stimulus process models the
// endpoint FIFOs as byte queues and derives the expected controller-side
// behaviour from packet rules; expected events are queued with the cycle they
// belong to, and a monitor on the falling clock edge compares them.
module tb_usb_in_ep_tx_sched;

  localparam int NUM_EP  = 4;
  localparam int MAX_PKT = 512;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        usbrst_i = 1'b0;
  logic [3:0]  endpt_i = '0;
  logic        txact_i = 1'b0;
  logic        txpop_i = 1'b0;
  logic        txpktfin_i = 1'b0;
  logic        txcork_o;
  logic [11:0] txdat_len_o;
  logic [7:0]  txdat_o;
  logic [NUM_EP*12-1:0] ep_avail_i = '0;
  logic [NUM_EP*8-1:0]  ep_dat_i = '0;
  logic [NUM_EP-1:0]    ep_rd_o;
  logic [NUM_EP-1:0]    ep_busy_o;
  logic                 overpop_o;

  usb_in_ep_tx_sched #(.NUM_EP(NUM_EP), .MAX_PKT(MAX_PKT)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .usbrst_i   (usbrst_i),
    .endpt_i    (endpt_i),
    .txact_i    (txact_i),
    .txpop_i    (txpop_i),
    .txpktfin_i (txpktfin_i),
    .txcork_o   (txcork_o),
    .txdat_len_o(txdat_len_o),
    .txdat_o    (txdat_o),
    .ep_avail_i (ep_avail_i),
    .ep_dat_i   (ep_dat_i),
    .ep_rd_o    (ep_rd_o),
    .ep_busy_o  (ep_busy_o),
    .overpop_o  (overpop_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    bit          is_pop;
    logic [3:0]  rd;
    logic [7:0]  dat;
    logic        cork;
    logic [11:0] len;
    logic [3:0]  busy;
    logic        ovp;
  } item_t;

  item_t      sb[$];
  logic [7:0] src[NUM_EP][$];
  int         ncyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         done = 1'b0;
  int         pend_pop = -1;
  logic       m_ovp = 1'b0;
  bit         zpend[NUM_EP];

  // ---------------- stimulus-side model helpers ----------------
  task automatic drive_src();
    for (int i = 0; i < NUM_EP; i++) begin
      ep_avail_i[i*12 +: 12] = 12'(src[i].size());
      ep_dat_i[i*8 +: 8]     = (src[i].size() > 0) ? src[i][0] : 8'h00;
    end
  endtask

  task automatic fill(input int i, input int n);
    for (int k = 0; k < n; k++) src[i].push_back(8'($urandom_range(0, 255)));
    drive_src();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pend_pop >= 0) void'(src[pend_pop].pop_front());
    pend_pop = -1;
    drive_src();
  endtask

  // What an idle scheduler should offer for endpoint ep.
  function automatic void exp_out(input int ep, output logic c, output logic [11:0] l);
    int n;
    if (ep < 1 || ep > NUM_EP) begin
      c = 1'b1;
      l = '0;
      return;
    end
    n = src[ep-1].size();
    l = 12'((n > MAX_PKT) ? MAX_PKT : n);
    c = (l == 0);
`ifdef USB_IN_ZLP_EN
    if (n == 0 && zpend[ep-1]) c = 1'b0;
`endif
  endfunction

  task automatic expect_stat(input logic c, input logic [11:0] l, input logic [3:0] b, input logic o);
    item_t it;
    it.tag = ncyc + 1; it.is_pop = 1'b0; it.rd = '0; it.dat = '0;
    it.cork = c; it.len = l; it.busy = b; it.ovp = o;
    sb.push_back(it);
  endtask

  task automatic expect_pop(input int idx);
    item_t it;
    it.tag = ncyc + 1; it.is_pop = 1'b1; it.rd = 4'(1 << idx); it.dat = src[idx][0];
    it.cork = 1'b0; it.len = '0; it.busy = '0; it.ovp = 1'b0;
    sb.push_back(it);
    pend_pop = idx;
  endtask

  // One IN transaction. np: >=0 pops, -1 exactly the packet, -2 random.
  // mode: 0 fin after pops, 1 fin with last pop, 2 txact falls instead of fin.
  task automatic txn(input int ep, input int np, input int mode);
    logic c; logic [11:0] l; logic [3:0] oh; int cnt; int n;
    endpt_i = 4'(ep);
    tick();
    exp_out(ep, c, l);
    expect_stat(c, l, 4'b0, m_ovp);
    txact_i = 1'b1;
    tick();
    if (c) begin
      expect_stat(1'b1, l, 4'b0, m_ovp);
      txpop_i = 1'b1;
      tick();
      txpop_i = 1'b0;
      txact_i = 1'b0;
      tick();
      return;
    end
    oh = 4'(1 << (ep - 1));
    expect_stat(1'b0, l, oh, m_ovp);
    n = np;
    if (np == -1) n = int'(l);
    else if (np == -2) n = int'($urandom_range(0, int'(l))) + (($urandom_range(0, 7) == 0) ? 1 : 0);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      txpop_i = 1'b1;
      if (mode == 1 && k == n - 1) txpktfin_i = 1'b1;
      if (cnt < int'(l)) begin
        expect_pop(ep - 1);
        cnt++;
      end else begin
        m_ovp = 1'b1;
      end
      tick();
    end
    txpop_i = 1'b0;
    if (!(mode == 1 && n > 0)) begin
      expect_stat(1'b0, l, oh, m_ovp);
      if (mode == 2) txact_i = 1'b0;
      else txpktfin_i = 1'b1;
      tick();
    end
`ifdef USB_IN_ZLP_EN
    if (mode != 2) begin
      if (cnt == MAX_PKT && src[ep-1].size() == 0) zpend[ep-1] = 1'b1;
      else if (l == 0) zpend[ep-1] = 1'b0;
    end
`endif
    txpktfin_i = 1'b0;
    txact_i    = 1'b0;
    expect_stat(1'b0, l, 4'b0, m_ovp);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic c; logic [11:0] l;
    for (int i = 0; i < NUM_EP; i++) zpend[i] = 1'b0;
    drive_src();
    @(posedge clk);
    #1;
    expect_stat(1'b1, 12'd0, 4'b0, 1'b0);
    tick();
    expect_stat(1'b1, 12'd0, 4'b0, 1'b0);
    reset_i = 1'b0;
    tick();

    // 100 bytes on endpoint 2
    fill(1, 100);
    txn(2, -1, 0);

    // 1300 bytes on endpoint 1: 512, 512, 276, then corked
    fill(0, 1300);
    txn(1, -1, 0);
    txn(1, -1, 0);
    txn(1, -1, 0);
    txn(1, 0, 0);

    // control endpoint and out-of-range endpoint NAK
    txn(0, 0, 0);
    txn(7, 0, 0);

    // four bytes, five pops: overpop sticks
    fill(2, 4);
    txn(3, 5, 0);
    txn(3, 0, 0);

    // last pop and packet finish in the same cycle
    fill(1, 6);
    txn(2, -1, 1);

    // full-size packet emptying its source, then the follow-up IN
    fill(0, 512);
    txn(1, -1, 0);
    txn(1, 0, 0);
    txn(1, 0, 0);

    // bus reset after two pops
    fill(3, 10);
    endpt_i = 4'd4;
    tick();
    txact_i = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      txpop_i = 1'b1;
      expect_pop(3);
      tick();
    end
    usbrst_i = 1'b1;
    tick();
    for (int i = 0; i < NUM_EP; i++) zpend[i] = 1'b0;
    expect_stat(1'b1, 12'd0, 4'b0, m_ovp);
    usbrst_i = 1'b0;
    txpop_i  = 1'b0;
    txact_i  = 1'b0;
    tick();
    exp_out(4, c, l);
    expect_stat(c, l, 4'b0, m_ovp);
    tick();

    // asynchronous reset in the middle of a packet
    txact_i = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      txpop_i = 1'b1;
      expect_pop(3);
      tick();
    end
    reset_i = 1'b1;
    m_ovp   = 1'b0;
    for (int i = 0; i < NUM_EP; i++) zpend[i] = 1'b0;
    expect_stat(1'b1, 12'd0, 4'b0, 1'b0);
    tick();
    reset_i = 1'b0;
    txpop_i = 1'b0;
    txact_i = 1'b0;
    tick();

    // randomized traffic
    for (int r = 0; r < 30; r++) begin
      int s;
      s = int'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0 && src[s].size() < 2000) fill(s, int'($urandom_range(0, 700)));
      txn(int'($urandom_range(0, 6)), -2, int'($urandom_range(0, 2)));
    end

    done = 1'b1;
    tick();
    tick();
  end

  // ---------------- monitor ----------------
  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, ncyc, got, exp);
    end
  endtask

  initial begin
    item_t it;
    bit got_pop;
    forever begin
      @(negedge clk);
      ncyc++;
      got_pop = 1'b0;
      while (sb.size() > 0 && sb[0].tag <= ncyc) begin
        it = sb.pop_front();
        if (it.tag != ncyc) begin
          cmp("sb_tag", 32'(it.tag), 32'(ncyc));
        end else if (it.is_pop) begin
          got_pop = 1'b1;
          cmp("ep_rd", 32'(ep_rd_o), 32'(it.rd));
          cmp("txdat", 32'(txdat_o), 32'(it.dat));
        end else begin
          cmp("txcork", 32'(txcork_o), 32'(it.cork));
          cmp("txdat_len", 32'(txdat_len_o), 32'(it.len));
          cmp("ep_busy", 32'(ep_busy_o), 32'(it.busy));
          cmp("overpop", 32'(overpop_o), 32'(it.ovp));
        end
      end
      if (!got_pop) cmp("ep_rd_quiet", 32'(ep_rd_o), 32'd0);
      if (ncyc > 60000) begin
        cmp("timeout", 32'd1, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      if (done) begin
        cmp("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

endmodule
